// File: rtl/calc_seq_core.sv
// calc_seq_core -- byte-serial sequential ALU.
//
// Operands A and B arrive one byte at a time, least-significant byte first.
// One EXEC cycle computes the result. The result then leaves one byte at a
// time, least-significant byte first.
//
// Optional feature: define CALC_SEQ_MUL_EN to build the multiplier for op 11.
// When it is undefined, op 11 is treated as an illegal opcode and no
// multiplier is built.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   op_sel     operation code, captured when start is accepted in IDLE
//   start      begin an operation (honoured only in IDLE)
//   in_data    operand byte stream
//   in_valid   operand byte valid; in_ready is high in LOAD_A/LOAD_B
//   out_data   result byte stream (zero outside OUT)
//   out_valid  result byte valid (high in OUT); out_ready from consumer
//   flags      {N,V,C,Z} from the most recent EXEC
//   err        most recent operation was illegal or disabled
//   busy       FSM not in IDLE
//   byte_idx   byte counter during LOAD_A/LOAD_B/OUT, zero otherwise
module calc_seq_core #(
  parameter  int WIDTH  = 16,
  localparam int NBYTES = WIDTH / 8,
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    op_sel,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    flags,
  output logic          err,
  output logic          busy,
  output logic [BW-1:0] byte_idx
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_OUT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [BW-1:0]    idx_q, idx_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic             last_byte;
  logic [WIDTH-1:0] alu_r;
  logic [WIDTH:0]   alu_wide;
  logic [WIDTH:0]   alu_shr;
  logic             alu_c, alu_v, alu_e;
  logic [SW-1:0]    shamt;

  assign last_byte = (idx_q == BW'(NBYTES - 1));
  assign shamt     = b_q[SW-1:0];

  // Combinational ALU, evaluated on the registered operands.
  always_comb begin
    alu_r    = '0;
    alu_wide = '0;
    alu_shr  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_e    = 1'b0;
    case (op_q)
      4'd0: begin
        alu_wide = {1'b0, a_q} + {1'b0, b_q};
        alu_r    = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
        alu_v    = (a_q[M] == b_q[M]) && (alu_r[M] != a_q[M]);
      end
      4'd1: begin
        // The extra top bit of the difference is the borrow.
        alu_wide = {1'b0, a_q} - {1'b0, b_q};
        alu_r    = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
        alu_v    = (a_q[M] != b_q[M]) && (alu_r[M] != a_q[M]);
      end
      4'd2: alu_r = a_q & b_q;
      4'd3: alu_r = a_q | b_q;
      4'd4: alu_r = a_q ^ b_q;
      4'd5: alu_r = ~a_q;
      4'd6: begin
        alu_wide = {1'b0, a_q} + (WIDTH+1)'(1);
        alu_r    = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
        alu_v    = ~a_q[M] & alu_r[M];
      end
      4'd7: begin
        alu_wide = {1'b0, a_q} - (WIDTH+1)'(1);
        alu_r    = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
        alu_v    = a_q[M] & ~alu_r[M];
      end
      4'd8: begin
        // The guard bit above the MSB catches the last bit shifted out. It
        // stays 0 when the shift amount is 0.
        alu_wide = {1'b0, a_q} << shamt;
        alu_r    = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      4'd9: begin
        alu_shr = {a_q, 1'b0} >> shamt;
        alu_r   = alu_shr[WIDTH:1];
        alu_c   = alu_shr[0];
      end
      4'd10: alu_r = (a_q < b_q) ? WIDTH'(1) : '0;
`ifdef CALC_SEQ_MUL_EN
      4'd11: alu_r = a_q * b_q;
`endif
      default: begin
        alu_r = '0;
        alu_e = 1'b1;
      end
    endcase
  end

  // Sequencing FSM and datapath next-state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_sel;
          idx_d   = '0;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        if (in_valid) begin
          for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == BW'(i)) begin
              if (state_q == S_LOAD_A) a_d[i*8 +: 8] = in_data;
              else                     b_d[i*8 +: 8] = in_data;
            end
          end
          if (last_byte) begin
            idx_d   = '0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_EXEC;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_EXEC: begin
        res_d   = alu_r;
        err_d   = alu_e;
        flags_d = {alu_r[M], alu_v, alu_c, (alu_r == '0)};
        idx_d   = '0;
        state_d = S_OUT;
      end
      S_OUT: begin
        // start is not sampled here, so a start that coincides with the
        // final transfer is dropped.
        if (out_ready) begin
          if (last_byte) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  // Result byte select. The selected byte is driven only while in OUT.
  always_comb begin
    out_data = '0;
    if (state_q == S_OUT) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (idx_q == BW'(i)) out_data = res_q[i*8 +: 8];
      end
    end
  end

  assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign byte_idx  = (in_ready || out_valid) ? idx_q : '0;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_calc_seq_core.sv
module tb_calc_seq_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] op_sel = '0;
  logic       start = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] flags;
  logic       err;
  logic       busy;
  logic [0:0] byte_idx;

  calc_seq_core #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .op_sel(op_sel), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flags(flags), .err(err), .busy(busy), .byte_idx(byte_idx)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  fl;
    logic        er;
  } vec_t;

  vec_t tv[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input bit start_in_out, output logic [15:0] res);
    res = '0;
    op_sel = op;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    op_sel = '0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = a[8*i +: 8];
      chk("in_ready_a", in_ready, 1);
      chk("idx_a", byte_idx, i);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = b[8*i +: 8];
      chk("in_ready_b", in_ready, 1);
      chk("idx_b", byte_idx, i);
      tick();
    end
    in_valid = 1'b0;
    chk("exec_out_valid", out_valid, 0);
    chk("exec_in_ready", in_ready, 0);
    tick();
    chk("latency_out_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("out_valid", out_valid, 1);
      chk("out_idx", byte_idx, i);
      res[8*i +: 8] = out_data;
      if (start_in_out) start = 1'b1;
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b0;
    chk("idle_after_out", busy, 0);
    if (start_in_out) begin
      tick();
      chk("start_in_out_ignored", busy, 0);
    end
  endtask

  initial begin
    logic [15:0] r;

    tv[0]  = '{4'd0,  16'h1234, 16'h0F0F, 16'h2143, 4'h0, 1'b0};
    tv[1]  = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'h3, 1'b0};
    tv[2]  = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'h4, 1'b0};
    tv[3]  = '{4'd1,  16'h0001, 16'h0002, 16'hFFFF, 4'hA, 1'b0};
    tv[4]  = '{4'd2,  16'hF0F0, 16'h3C3C, 16'h3030, 4'h0, 1'b0};
    tv[5]  = '{4'd3,  16'h00F0, 16'h0F00, 16'h0FF0, 4'h0, 1'b0};
    tv[6]  = '{4'd4,  16'hAAAA, 16'hAAAA, 16'h0000, 4'h1, 1'b0};
    tv[7]  = '{4'd5,  16'h00FF, 16'h1234, 16'hFF00, 4'h8, 1'b0};
    tv[8]  = '{4'd6,  16'h7FFF, 16'h5555, 16'h8000, 4'hC, 1'b0};
    tv[9]  = '{4'd7,  16'h0000, 16'h5555, 16'hFFFF, 4'hA, 1'b0};
    tv[10] = '{4'd8,  16'h8001, 16'h0011, 16'h0002, 4'h2, 1'b0};
    tv[11] = '{4'd9,  16'h0003, 16'h0001, 16'h0001, 4'h2, 1'b0};
    tv[12] = '{4'd8,  16'h1234, 16'h0000, 16'h1234, 4'h0, 1'b0};
    tv[13] = '{4'd10, 16'h0001, 16'h8000, 16'h0001, 4'h0, 1'b0};
    tv[14] = '{4'd10, 16'h8000, 16'h0001, 16'h0000, 4'h1, 1'b0};
`ifdef CALC_SEQ_MUL_EN
    tv[15] = '{4'd11, 16'h0100, 16'h0003, 16'h0300, 4'h0, 1'b0};
`else
    tv[15] = '{4'd11, 16'h0100, 16'h0003, 16'h0000, 4'h1, 1'b1};
`endif
    tv[16] = '{4'd12, 16'h0005, 16'h0006, 16'h0000, 4'h1, 1'b1};
    tv[17] = '{4'd6,  16'hFFFF, 16'h0000, 16'h0000, 4'h3, 1'b0};
    tv[18] = '{4'd15, 16'h1111, 16'h2222, 16'h0000, 4'h1, 1'b1};

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err", err, 0);
    chk("rst_byte_idx", byte_idx, 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 19; k++) begin
      run_op(tv[k].op, tv[k].a, tv[k].b, 1'b0, r);
      chk($sformatf("vec%0d_res", k), r, tv[k].res);
      chk($sformatf("vec%0d_flags", k), flags, tv[k].fl);
      chk($sformatf("vec%0d_err", k), err, tv[k].er);
    end

    // Flags/err held from the last EXEC (illegal op 15) into the next load,
    // then an asynchronous reset mid-load after one A byte.
    op_sel = 4'd0;
    start  = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    in_valid = 1'b0;
    chk("hold_err", err, 1);
    chk("hold_flags", flags, 4'h1);
    chk("mid_idx", byte_idx, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_idx", byte_idx, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_err", err, 0);
    chk("arst_flags", flags, 0);
    #1;
    rst = 1'b0;
    tick();
    run_op(4'd0, 16'h0001, 16'h0001, 1'b1, r);
    chk("post_rst_res", r, 16'h0002);
    chk("post_rst_flags", flags, 4'h0);
    chk("post_rst_err", err, 0);

    // XOR with the consumer stalled for 5 cycles
    op_sel = 4'd4;
    start  = 1'b1;
    tick();
    start = 1'b0;
    begin
      logic [7:0] bytes [4];
      bytes[0] = 8'h34; bytes[1] = 8'h12; bytes[2] = 8'hFF; bytes[3] = 8'h00;
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1;
        in_data  = bytes[i];
        tick();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 5; s++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'hCB);
      chk("stall_idx", byte_idx, 0);
      tick();
    end
    out_ready = 1'b1;
    chk("rel_data0", out_data, 8'hCB);
    chk("rel_idx0", byte_idx, 0);
    tick();
    chk("rel_data1", out_data, 8'h12);
    chk("rel_idx1", byte_idx, 1);
    tick();
    out_ready = 1'b0;
    chk("rel_idle", busy, 0);
    chk("rel_flags", flags, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
